// File: rtl/icache_miss_handler_pkg.sv
// Shared fetch-side definitions for the L1I miss handler.
//   - default parameter widths for address, line, PID/TID/major-ID, memory bus
//   - line-offset-bit constant and helper to derive it for other line sizes
//   - miss handler FSM state encoding
package icache_miss_handler_pkg;

   localparam int DEFAULT_ADDR_W     = 64;
   localparam int DEFAULT_LINE_W     = 512;
   localparam int DEFAULT_PID_W      = 32;
   localparam int DEFAULT_TID_W      = 64;
   localparam int DEFAULT_ICNT_W     = 64;
   localparam int DEFAULT_MEM_BUS_W  = 128;

   // Byte-offset bits inside a line (6 for a 64-byte line).
   localparam int LINE_OFFSET_BITS   = $clog2(DEFAULT_LINE_W / 8);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_REQ    = 2'd1,
      ST_FILL   = 2'd2,
      ST_UPDATE = 2'd3
   } miss_state_t;

   function automatic int line_offset_bits(input int line_w);
      return $clog2(line_w / 8);
   endfunction

endpackage

// File: rtl/line_assembler.sv
// Collects memory response beats into one cache line.
//   clk, rst      : clock, synchronous active-high reset
//   clear         : holds the beat counter at zero (asserted outside FILL)
//   beat_valid    : accepted response beat this cycle
//   beat_data     : beat payload
//   line          : assembled line, beat 0 in the least significant bits
//   last_beat     : counter is at the final beat index
module line_assembler
   import icache_miss_handler_pkg::*;
#(
   parameter int LINE_W = DEFAULT_LINE_W,
   parameter int BUS_W  = DEFAULT_MEM_BUS_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clear,
   input  logic              beat_valid,
   input  logic [BUS_W-1:0]  beat_data,
   output logic [LINE_W-1:0] line,
   output logic              last_beat
);

   localparam int BEATS = LINE_W / BUS_W;
   localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(BEATS - 1);

   logic [CNT_W-1:0]  count;
   logic [LINE_W-1:0] line_q;

   // Saturates at the last index; the FSM leaves FILL on that beat.
   always_ff @(posedge clk) begin
      if (rst || clear) begin
         count <= '0;
      end else if (beat_valid && (count != LAST)) begin
         count <= count + 1'b1;
      end
   end

   // Shifting in from the top places beat i at bits [i*BUS_W +: BUS_W]
   // once all beats have arrived, without a variable part-select.
   generate
      if (BEATS > 1) begin : g_shift
         always_ff @(posedge clk) begin
            if (rst) begin
               line_q <= '0;
            end else if (beat_valid) begin
               line_q <= {beat_data, line_q[LINE_W-1:BUS_W]};
            end
         end
      end else begin : g_single
         always_ff @(posedge clk) begin
            if (rst) begin
               line_q <= '0;
            end else if (beat_valid) begin
               line_q <= beat_data;
            end
         end
      end
   endgenerate

   assign line      = line_q;
   assign last_beat = (count == LAST);

endmodule

// File: rtl/icache_miss_handler.sv
// L1 instruction cache miss handler.
// Latches a fetch miss, issues one line-aligned read, assembles the response
// beats and hands the completed line back to fetch with the miss context.
//   clock_i, reset_i         : clock, synchronous active-high reset
//   cacheMiss_i + missed*_i  : miss pulse and context from fetch
//   memReq*                  : read request handshake, line-aligned address
//   memResp*                 : response beats, with bus error flag
//   cacheUpdate*_o, missedInstMajorId_o : one-cycle fill to fetch
//   busy_o                   : miss in flight
//   fetchError_o             : one-cycle pulse on a response bus error
module icache_miss_handler
   import icache_miss_handler_pkg::*;
#(
   parameter int addressWidth            = DEFAULT_ADDR_W,
   parameter int cacheLineWidth          = DEFAULT_LINE_W,
   parameter int PidSize                 = DEFAULT_PID_W,
   parameter int TidSize                 = DEFAULT_TID_W,
   parameter int instructionCounterWidth = DEFAULT_ICNT_W,
   parameter int memBusWidth             = DEFAULT_MEM_BUS_W
) (
   input  logic                               clock_i,
   input  logic                               reset_i,
   input  logic                               cacheMiss_i,
   input  logic [addressWidth-1:0]            missedAddress_i,
   input  logic [instructionCounterWidth-1:0] missedInstMajorId_i,
   input  logic [PidSize-1:0]                 missedPid_i,
   input  logic [TidSize-1:0]                 missedTid_i,
   output logic                               memReqValid_o,
   input  logic                               memReqReady_i,
   output logic [addressWidth-1:0]            memReqAddress_o,
   input  logic                               memRespValid_i,
   input  logic [memBusWidth-1:0]             memRespData_i,
   input  logic                               memRespErr_i,
   output logic                               cacheUpdate_o,
   output logic [addressWidth-1:0]            cacheUpdateAddress_o,
   output logic [PidSize-1:0]                 cacheUpdatePid_o,
   output logic [TidSize-1:0]                 cacheUpdateTid_o,
   output logic [instructionCounterWidth-1:0] missedInstMajorId_o,
   output logic [cacheLineWidth-1:0]          cacheUpdateLine_o,
   output logic                               busy_o,
   output logic                               fetchError_o
);

   localparam int OFF = line_offset_bits(cacheLineWidth);
   localparam logic [addressWidth-1:0] LINE_MASK =
      {{(addressWidth - OFF){1'b1}}, {OFF{1'b0}}};

   miss_state_t state, state_next;

   logic [addressWidth-1:0]            line_addr;
   logic [instructionCounterWidth-1:0] major_id;
   logic [PidSize-1:0]                 pid;
   logic [TidSize-1:0]                 tid;
   logic                               fetch_error;

   logic                      miss_accept;
   logic                      beat_ok;
   logic                      beat_err;
   logic                      asm_clear;
   logic                      asm_last;
   logic [cacheLineWidth-1:0] asm_line;

   logic mem_req_valid;
   logic cache_update;
   logic busy;

   assign miss_accept = (state == ST_IDLE) && cacheMiss_i;
   assign beat_ok     = (state == ST_FILL) && memRespValid_i && !memRespErr_i;
   assign beat_err    = (state == ST_FILL) && memRespValid_i && memRespErr_i;
   assign asm_clear   = (state != ST_FILL);

   line_assembler #(
      .LINE_W (cacheLineWidth),
      .BUS_W  (memBusWidth)
   ) u_line_assembler (
      .clk        (clock_i),
      .rst        (reset_i),
      .clear      (asm_clear),
      .beat_valid (beat_ok),
      .beat_data  (memRespData_i),
      .line       (asm_line),
      .last_beat  (asm_last)
   );

   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         state <= ST_IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         line_addr <= '0;
         major_id  <= '0;
         pid       <= '0;
         tid       <= '0;
      end else if (miss_accept) begin
         line_addr <= missedAddress_i & LINE_MASK;
         major_id  <= missedInstMajorId_i;
         pid       <= missedPid_i;
         tid       <= missedTid_i;
      end
   end

   // Registered so the pulse lands in the first IDLE cycle after the error.
   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         fetch_error <= 1'b0;
      end else begin
         fetch_error <= beat_err;
      end
   end

   always_comb begin
      state_next    = state;
      mem_req_valid = 1'b0;
      cache_update  = 1'b0;
      busy          = 1'b1;
      case (state)
         ST_IDLE: begin
            busy = 1'b0;
            if (cacheMiss_i) begin
               state_next = ST_REQ;
            end
         end
         ST_REQ: begin
            mem_req_valid = 1'b1;
            if (memReqReady_i) begin
               state_next = ST_FILL;
            end
         end
         ST_FILL: begin
            if (beat_err) begin
               state_next = ST_IDLE;
            end else if (beat_ok && asm_last) begin
               state_next = ST_UPDATE;
            end
         end
         ST_UPDATE: begin
            cache_update = 1'b1;
            state_next   = ST_IDLE;
         end
         default: begin
            busy       = 1'b0;
            state_next = ST_IDLE;
         end
      endcase
   end

   // Data outputs are gated so they read zero outside their valid cycles.
   assign memReqValid_o        = mem_req_valid;
   assign memReqAddress_o      = mem_req_valid ? line_addr : '0;
   assign cacheUpdate_o        = cache_update;
   assign cacheUpdateAddress_o = cache_update ? line_addr : '0;
   assign cacheUpdatePid_o     = cache_update ? pid : '0;
   assign cacheUpdateTid_o     = cache_update ? tid : '0;
   assign missedInstMajorId_o  = cache_update ? major_id : '0;
   assign cacheUpdateLine_o    = cache_update ? asm_line : '0;
   assign busy_o               = busy;
   assign fetchError_o         = fetch_error;

endmodule

// File: tb/tb_icache_miss_handler.sv
module tb_icache_miss_handler;

   logic         clock_i = 1'b0;
   logic         reset_i;
   logic         cacheMiss_i;
   logic [63:0]  missedAddress_i;
   logic [63:0]  missedInstMajorId_i;
   logic [31:0]  missedPid_i;
   logic [63:0]  missedTid_i;
   logic         memReqValid_o;
   logic         memReqReady_i;
   logic [63:0]  memReqAddress_o;
   logic         memRespValid_i;
   logic [127:0] memRespData_i;
   logic         memRespErr_i;
   logic         cacheUpdate_o;
   logic [63:0]  cacheUpdateAddress_o;
   logic [31:0]  cacheUpdatePid_o;
   logic [63:0]  cacheUpdateTid_o;
   logic [63:0]  missedInstMajorId_o;
   logic [511:0] cacheUpdateLine_o;
   logic         busy_o;
   logic         fetchError_o;

   icache_miss_handler dut (
      .clock_i              (clock_i),
      .reset_i              (reset_i),
      .cacheMiss_i          (cacheMiss_i),
      .missedAddress_i      (missedAddress_i),
      .missedInstMajorId_i  (missedInstMajorId_i),
      .missedPid_i          (missedPid_i),
      .missedTid_i          (missedTid_i),
      .memReqValid_o        (memReqValid_o),
      .memReqReady_i        (memReqReady_i),
      .memReqAddress_o      (memReqAddress_o),
      .memRespValid_i       (memRespValid_i),
      .memRespData_i        (memRespData_i),
      .memRespErr_i         (memRespErr_i),
      .cacheUpdate_o        (cacheUpdate_o),
      .cacheUpdateAddress_o (cacheUpdateAddress_o),
      .cacheUpdatePid_o     (cacheUpdatePid_o),
      .cacheUpdateTid_o     (cacheUpdateTid_o),
      .missedInstMajorId_o  (missedInstMajorId_o),
      .cacheUpdateLine_o    (cacheUpdateLine_o),
      .busy_o               (busy_o),
      .fetchError_o         (fetchError_o)
   );

   always #5 clock_i = ~clock_i;

   int cyc = 0;
   always @(posedge clock_i) cyc <= cyc + 1;

   typedef struct {
      logic [63:0]  addr;
      logic [63:0]  id;
      logic [31:0]  pid;
      logic [63:0]  tid;
      logic [511:0] line;
      int           at;
   } upd_t;

   upd_t        upd_q[$];
   logic [63:0] req_q[$];
   int          err_q[$];

   int checks = 0;
   int errors = 0;

   localparam logic [127:0] B1 = {16{8'h11}};
   localparam logic [127:0] B2 = {16{8'h22}};
   localparam logic [127:0] B3 = {16{8'h33}};
   localparam logic [127:0] B4 = {16{8'h44}};

   task automatic tick();
      @(posedge clock_i);
      #1;
   endtask

   // Observes every cycle and pops the scoreboard on each DUT event.
   task automatic monitor();
      upd_t        u;
      logic [63:0] r;
      int          e;
      forever begin
         @(negedge clock_i);
         if (memReqValid_o === 1'b1 && memReqReady_i === 1'b1) begin
            checks++;
            if (req_q.size() == 0) begin
               errors++;
               $display("FAIL unexpected_req got=%h want=none", memReqAddress_o);
            end else begin
               r = req_q.pop_front();
               if (memReqAddress_o !== r) begin
                  errors++;
                  $display("FAIL req_addr got=%h want=%h", memReqAddress_o, r);
               end
            end
         end
         if (cacheUpdate_o === 1'b1) begin
            checks++;
            if (upd_q.size() == 0) begin
               errors++;
               $display("FAIL unexpected_update addr=%h at cycle %0d", cacheUpdateAddress_o, cyc);
            end else begin
               u = upd_q.pop_front();
               if (cacheUpdateLine_o !== u.line) begin
                  errors++;
                  $display("FAIL upd_line got=%h want=%h", cacheUpdateLine_o, u.line);
               end
               checks++;
               if ({cacheUpdateAddress_o, missedInstMajorId_o, cacheUpdatePid_o, cacheUpdateTid_o}
                   !== {u.addr, u.id, u.pid, u.tid}) begin
                  errors++;
                  $display("FAIL upd_ctx got=%h/%0d/%0d/%0d want=%h/%0d/%0d/%0d",
                           cacheUpdateAddress_o, missedInstMajorId_o, cacheUpdatePid_o, cacheUpdateTid_o,
                           u.addr, u.id, u.pid, u.tid);
               end
               checks++;
               if (cyc !== u.at) begin
                  errors++;
                  $display("FAIL upd_latency got=cycle %0d want=cycle %0d", cyc, u.at);
               end
            end
            checks++;
            if (memReqValid_o !== 1'b0) begin
               errors++;
               $display("FAIL upd_req_overlap got=%b want=0", memReqValid_o);
            end
         end
         if (fetchError_o === 1'b1) begin
            checks++;
            if (err_q.size() == 0) begin
               errors++;
               $display("FAIL unexpected_fetch_error at cycle %0d", cyc);
            end else begin
               e = err_q.pop_front();
               if (cyc !== e) begin
                  errors++;
                  $display("FAIL err_cycle got=%0d want=%0d", cyc, e);
               end
            end
         end
      end
   endtask

   // Drives one miss and its memory side; pushes the expected outcome first.
   // err_beat < 0: no error. intr_beat 0..3: extra miss alongside that beat;
   // 4: extra miss in the update cycle; < 0: none.
   task automatic drive_fill(input logic [63:0] addr, input logic [63:0] id,
                             input logic [31:0] pid, input logic [63:0] tid,
                             input logic [127:0] b0, input logic [127:0] b1,
                             input logic [127:0] b2, input logic [127:0] b3,
                             input int stall, input int gap,
                             input int err_beat, input int intr_beat);
      logic [127:0] beats [4];
      upd_t u;
      int   m;
      int   f;
      beats[0] = b0; beats[1] = b1; beats[2] = b2; beats[3] = b3;
      m = cyc;
      f = m + 2 + stall;
      req_q.push_back({addr[63:6], 6'b0});
      if (err_beat < 0) begin
         u.addr = {addr[63:6], 6'b0};
         u.id   = id;
         u.pid  = pid;
         u.tid  = tid;
         u.line = {b3, b2, b1, b0};
         u.at   = f + 3 * (1 + gap) + 1;
         upd_q.push_back(u);
      end else begin
         err_q.push_back(f + err_beat * (1 + gap) + 1);
      end
      cacheMiss_i         = 1'b1;
      missedAddress_i     = addr;
      missedInstMajorId_i = id;
      missedPid_i         = pid;
      missedTid_i         = tid;
      memReqReady_i       = (stall == 0);
      tick();
      cacheMiss_i = 1'b0;
      repeat (stall) tick();
      memReqReady_i = 1'b1;
      tick();
      for (int i = 0; i < 4; i++) begin
         memRespValid_i = 1'b1;
         memRespData_i  = beats[i];
         memRespErr_i   = (i == err_beat);
         if (i == intr_beat) begin
            cacheMiss_i     = 1'b1;
            missedAddress_i = 64'h2000;
            missedPid_i     = 32'd5;
         end
         tick();
         memRespValid_i = 1'b0;
         memRespErr_i   = 1'b0;
         cacheMiss_i    = 1'b0;
         if (i == err_beat) break;
         if (i < 3) repeat (gap) tick();
      end
      if (intr_beat == 4) begin
         cacheMiss_i     = 1'b1;
         missedAddress_i = 64'h3000;
         tick();
         cacheMiss_i = 1'b0;
      end
   endtask

   task automatic test_reset();
      reset_i = 1'b1;
      repeat (3) tick();
      @(negedge clock_i);
      checks++;
      if ({memReqValid_o, cacheUpdate_o, busy_o, fetchError_o} !== 4'b0 ||
          memReqAddress_o !== '0 || cacheUpdateLine_o !== '0) begin
         errors++;
         $display("FAIL reset_outputs got=v%b u%b b%b e%b a=%h want=all zero",
                  memReqValid_o, cacheUpdate_o, busy_o, fetchError_o, memReqAddress_o);
      end
      tick();
      reset_i = 1'b0;
      tick();
      @(negedge clock_i);
      checks++;
      if (busy_o !== 1'b0) begin
         errors++;
         $display("FAIL reset_idle_busy got=%b want=0", busy_o);
      end
      tick();
   endtask

   task automatic test_nominal();
      drive_fill(64'h1234, 64'd7, 32'd3, 64'd9, B1, B2, B3, B4, 0, 0, -1, -1);
      tick();
      @(negedge clock_i);
      checks++;
      if (busy_o !== 1'b0) begin
         errors++;
         $display("FAIL nominal_idle_busy got=%b want=0", busy_o);
      end
      checks++;
      if (upd_q.size() != 0 || req_q.size() != 0) begin
         errors++;
         $display("FAIL nominal_pending got=%0d/%0d want=0/0", upd_q.size(), req_q.size());
      end
      tick();
   endtask

   task automatic test_req_stall();
      int m;
      m = cyc;
      fork
         drive_fill(64'h1234, 64'd7, 32'd3, 64'd9, B1, B2, B3, B4, 3, 0, -1, -1);
         begin
            @(negedge clock_i);
            for (int k = 1; k <= 4; k++) begin
               @(negedge clock_i);
               checks++;
               if (memReqValid_o !== 1'b1 || memReqAddress_o !== 64'h1200) begin
                  errors++;
                  $display("FAIL stall_hold cycle %0d got=%b/%h want=1/%h",
                           k, memReqValid_o, memReqAddress_o, 64'h1200);
               end
            end
            @(negedge clock_i);
            checks++;
            if (memReqValid_o !== 1'b0) begin
               errors++;
               $display("FAIL stall_release got=%b want=0", memReqValid_o);
            end
         end
      join
      tick();
      @(negedge clock_i);
      checks++;
      if (upd_q.size() != 0 || req_q.size() != 0) begin
         errors++;
         $display("FAIL stall_pending got=%0d/%0d want=0/0 (start %0d)", upd_q.size(), req_q.size(), m);
      end
      tick();
   endtask

   task automatic test_gapped_beats();
      fork
         drive_fill(64'h1234, 64'd7, 32'd3, 64'd9, B1, B2, B3, B4, 0, 1, -1, -1);
         begin
            @(negedge clock_i);
            for (int k = 1; k <= 9; k++) begin
               @(negedge clock_i);
               checks++;
               if (busy_o !== 1'b1) begin
                  errors++;
                  $display("FAIL gap_busy cycle %0d got=%b want=1", k, busy_o);
               end
            end
         end
      join
      tick();
      @(negedge clock_i);
      checks++;
      if (upd_q.size() != 0 || req_q.size() != 0) begin
         errors++;
         $display("FAIL gap_pending got=%0d/%0d want=0/0", upd_q.size(), req_q.size());
      end
      tick();
   endtask

   task automatic test_miss_while_busy();
      drive_fill(64'h1234, 64'd7, 32'd3, 64'd9, B1, B2, B3, B4, 0, 0, -1, 1);
      repeat (2) tick();
      drive_fill(64'h5678, 64'd8, 32'd4, 64'd10, B4, B3, B2, B1, 0, 0, -1, 4);
      repeat (3) tick();
      @(negedge clock_i);
      checks++;
      if (busy_o !== 1'b0) begin
         errors++;
         $display("FAIL busy_miss_dropped got=%b want=0", busy_o);
      end
      checks++;
      if (upd_q.size() != 0 || req_q.size() != 0) begin
         errors++;
         $display("FAIL busy_pending got=%0d/%0d want=0/0", upd_q.size(), req_q.size());
      end
      tick();
   endtask

   task automatic test_error();
      drive_fill(64'h9abc, 64'd1, 32'd2, 64'd3, B1, B2, B3, B4, 0, 0, 2, -1);
      @(negedge clock_i);
      checks++;
      if (fetchError_o !== 1'b1 || busy_o !== 1'b0) begin
         errors++;
         $display("FAIL err_pulse got=e%b b%b want=e1 b0", fetchError_o, busy_o);
      end
      tick();
      @(negedge clock_i);
      checks++;
      if (fetchError_o !== 1'b0) begin
         errors++;
         $display("FAIL err_single got=%b want=0", fetchError_o);
      end
      tick();
      drive_fill(64'h4567, 64'd11, 32'd12, 64'd13, B2, B4, B1, B3, 0, 0, -1, -1);
      tick();
      @(negedge clock_i);
      checks++;
      if (upd_q.size() != 0 || req_q.size() != 0 || err_q.size() != 0) begin
         errors++;
         $display("FAIL err_pending got=%0d/%0d/%0d want=0/0/0", upd_q.size(), req_q.size(), err_q.size());
      end
      tick();
   endtask

   task automatic test_reset_mid_fill();
      req_q.push_back(64'h1200);
      cacheMiss_i         = 1'b1;
      missedAddress_i     = 64'h1234;
      missedInstMajorId_i = 64'd7;
      missedPid_i         = 32'd3;
      missedTid_i         = 64'd9;
      memReqReady_i       = 1'b1;
      tick();
      cacheMiss_i = 1'b0;
      tick();
      memRespValid_i = 1'b1;
      memRespData_i  = B1;
      tick();
      memRespData_i  = B2;
      tick();
      memRespValid_i = 1'b0;
      reset_i        = 1'b1;
      tick();
      reset_i = 1'b0;
      for (int k = 0; k < 2; k++) begin
         memRespValid_i = 1'b1;
         memRespData_i  = (k == 0) ? B3 : B4;
         @(negedge clock_i);
         checks++;
         if ({memReqValid_o, cacheUpdate_o, busy_o, fetchError_o} !== 4'b0 ||
             cacheUpdateLine_o !== '0) begin
            errors++;
            $display("FAIL rst_fill_outputs beat %0d got=v%b u%b b%b e%b want=all zero",
                     k, memReqValid_o, cacheUpdate_o, busy_o, fetchError_o);
         end
         tick();
      end
      memRespValid_i = 1'b0;
      tick();
      drive_fill(64'hdead_beef_0000_0fc7, 64'd21, 32'd22, 64'd23,
                 {16{8'haa}}, {16{8'hbb}}, {16{8'hcc}}, {16{8'hdd}}, 0, 0, -1, -1);
      tick();
      @(negedge clock_i);
      checks++;
      if (upd_q.size() != 0 || req_q.size() != 0) begin
         errors++;
         $display("FAIL rst_fill_pending got=%0d/%0d want=0/0", upd_q.size(), req_q.size());
      end
      tick();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog timeout at cycle %0d", cyc);
      $fatal(1, "timeout");
   end

   initial begin
      reset_i             = 1'b1;
      cacheMiss_i         = 1'b0;
      missedAddress_i     = '0;
      missedInstMajorId_i = '0;
      missedPid_i         = '0;
      missedTid_i         = '0;
      memReqReady_i       = 1'b1;
      memRespValid_i      = 1'b0;
      memRespData_i       = '0;
      memRespErr_i        = 1'b0;
      fork
         monitor();
      join_none
      test_reset();
      test_nominal();
      test_req_stall();
      test_gapped_beats();
      test_miss_while_busy();
      test_error();
      test_reset_mid_fill();
      repeat (3) tick();
      checks++;
      if (upd_q.size() != 0 || req_q.size() != 0 || err_q.size() != 0) begin
         errors++;
         $display("FAIL final_pending got=%0d/%0d/%0d want=0/0/0", upd_q.size(), req_q.size(), err_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
